ace_snoop_collector: RTL

- Fans one upstream ACE snoop request (AC) out to NumPorts cached masters, collects their snoop responses (CR), merges them into one response toward the interconnect/home node.
- Generalises the ACE snoop types (acsnoop_t, acprot_t, crresp_t) to a parametrised N-way broadcast with per-request target masks, a response-merge policy, data-owner selection and a per-transaction timeout.
- Sits in the coherency interconnect between the request-side snoop generator and the per-master AC/CR channels. The CD channel is handled elsewhere; this block only reports which port supplies data.

---
 rtl/ace_snoop_collector.sv | 109 ++++++++++
 1 files changed

// File: rtl/ace_snoop_collector.sv
// ace_snoop_collector: fans one ACE snoop out to NumPorts masters and merges their CR responses
module ace_snoop_collector #(
  parameter int NumPorts = 4,
  parameter int AddrWidth = 64,
  parameter int TimeoutCycles = 0,
  localparam int IdxWidth = NumPorts > 1 ? $clog2(NumPorts) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ac_valid_i,
  output logic                  ac_ready_o,
  input  logic [AddrWidth-1:0]  ac_addr_i,
  input  logic [3:0]            ac_snoop_i,
  input  logic [2:0]            ac_prot_i,
  input  logic [NumPorts-1:0]   ac_mask_i,
  output logic [NumPorts-1:0]   mst_ac_valid_o,
  input  logic [NumPorts-1:0]   mst_ac_ready_i,
  output logic [AddrWidth-1:0]  mst_ac_addr_o,
  output logic [3:0]            mst_ac_snoop_o,
  output logic [2:0]            mst_ac_prot_o,
  input  logic [NumPorts-1:0]   mst_cr_valid_i,
  output logic [NumPorts-1:0]   mst_cr_ready_o,
  input  logic [5*NumPorts-1:0] mst_cr_resp_i,
  output logic                  cr_valid_o,
  input  logic                  cr_ready_i,
  output logic [4:0]            cr_resp_o,
  output logic [IdxWidth-1:0]   cr_data_sel_o,
  output logic [NumPorts-1:0]   cr_timeout_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, SNOOP, RESP} state_t;
  state_t state, state_nx;
  logic [NumPorts-1:0] target, acdone, done, stale, dtm, tmo;
  logic [NumPorts-1:0] pend, ac_hs_m, cr_hs, drain, done_nx, dt_nx;
  logic [4:0] acc, merged;
  logic [31:0] cnt;
  logic ac_hs, expire;
  assign cr_resp_o = acc;
  assign cr_timeout_o = tmo;
  always_comb begin
    ac_ready_o = state == IDLE;
    ac_hs = ac_valid_i & ac_ready_o;
    busy_o = state != IDLE;
    cr_valid_o = state == RESP;
    mst_ac_valid_o = state == SNOOP ? target & ~acdone : '0;
    ac_hs_m = mst_ac_valid_o & mst_ac_ready_i;
    pend = state == SNOOP ? acdone & ~done : '0;
    mst_cr_ready_o = pend | stale;
    cr_hs = mst_cr_valid_i & pend;
    drain = mst_cr_valid_i & stale;
    done_nx = done | cr_hs;
    merged = acc;
    dt_nx = dtm;
    for (int i = 0; i < NumPorts; i++)
      if (cr_hs[i]) begin
        merged = merged | mst_cr_resp_i[5*i +: 5];
        dt_nx[i] = mst_cr_resp_i[5*i];
      end
    expire = TimeoutCycles != 0 && cnt == 32'(TimeoutCycles - 1) && done_nx != target;
    cr_data_sel_o = '0;
    for (int i = NumPorts - 1; i >= 0; i--)
      if (dtm[i]) cr_data_sel_o = IdxWidth'(i);
    state_nx = state == IDLE  ? (ac_valid_i ? (|(ac_mask_i & ~stale) ? SNOOP : RESP) : IDLE) :
               state == SNOOP ? (done_nx == target || expire ? RESP : SNOOP) :
                                (cr_ready_i ? IDLE : RESP);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      target <= '0;
      acdone <= '0;
      done <= '0;
      stale <= '0;
      dtm <= '0;
      tmo <= '0;
      acc <= '0;
      cnt <= '0;
      mst_ac_addr_o <= '0;
      mst_ac_snoop_o <= '0;
      mst_ac_prot_o <= '0;
    end else begin
      state <= state_nx;
      stale <= (stale & ~drain) | (expire ? (acdone | ac_hs_m) & ~done_nx : '0);
      if (ac_hs) begin
        mst_ac_addr_o <= ac_addr_i;
        mst_ac_snoop_o <= ac_snoop_i;
        mst_ac_prot_o <= ac_prot_i;
        target <= ac_mask_i & ~stale;
        tmo <= ac_mask_i & stale;
        acc <= {3'b000, |(ac_mask_i & stale), 1'b0};
        acdone <= '0;
        done <= '0;
        dtm <= '0;
        cnt <= '0;
      end else if (state == SNOOP) begin
        acdone <= acdone | ac_hs_m;
        done <= done_nx;
        acc <= expire ? merged | 5'b00010 : merged;
        dtm <= dt_nx;
        cnt <= cnt + 1;
        tmo <= expire ? tmo | (target & ~done_nx) : tmo;
      end else if (state == RESP && cr_ready_i) begin
        acc <= '0;
        tmo <= '0;
        dtm <= '0;
      end
    end
  end
endmodule
